dram_cmd_issuer: RTL and testbench

Stage directly downstream of request_scheduler. It accepts the scheduler's DRAM commands (ACT/READ/WRITE/PRE) over a valid/ready handshake and enforces per-bank and global DRAM timing before driving the command onto the DRAM command bus. It also tracks outstanding reads in an in-order queue and returns read data tagged with the originating physical address.

---
 rtl/dram_cmd_issuer.sv | 231 +++++++++++++++++++++++
 tb/tb_dram_cmd_issuer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_cmd_issuer.sv
// DRAM command issuer: enforces per-bank and global timing on scheduler commands,
// drives them onto the DRAM command bus and returns read data tagged with its address.
module dram_cmd_issuer #(
  parameter int BANK_GROUPS     = 8,
  parameter int BANKS_PER_GROUP = 8,
  parameter int ROW_BITS        = 8,
  parameter int COL_BITS        = 4,
  parameter int PADDR_BITS      = 19,
  parameter int T_RCD           = 8,
  parameter int T_RP            = 5,
  parameter int T_RAS           = 12,
  parameter int T_WR            = 6,
  parameter int T_CCD           = 2,
  parameter int RQ_DEPTH        = 8
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic [2:0]                         cmd_in,
  input  logic                               valid_in,
  input  logic [PADDR_BITS-1:0]              addr_in,
  input  logic [$clog2(BANK_GROUPS)-1:0]     bank_group_in,
  input  logic [$clog2(BANKS_PER_GROUP)-1:0] bank_in,
  input  logic [ROW_BITS-1:0]                row_in,
  input  logic [COL_BITS-1:0]                col_in,
  input  logic [511:0]                       val_in,
  output logic                               cmd_ready,
  output logic [2:0]                         dram_cmd_out,
  output logic [$clog2(BANK_GROUPS)-1:0]     dram_bg_out,
  output logic [$clog2(BANKS_PER_GROUP)-1:0] dram_ba_out,
  output logic [ROW_BITS-1:0]                dram_addr_out,
  output logic [511:0]                       dram_wdata_out,
  input  logic [511:0]                       dram_rdata_in,
  input  logic                               dram_rvalid_in,
  output logic                               rsp_valid_out,
  output logic [PADDR_BITS-1:0]              rsp_addr_out,
  output logic [511:0]                       rsp_data_out,
  output logic                               protocol_err_out
);

  localparam int BG_W      = $clog2(BANK_GROUPS);
  localparam int BA_W      = $clog2(BANKS_PER_GROUP);
  localparam int NUM_BANKS = BANK_GROUPS * BANKS_PER_GROUP;
  localparam int BK_W      = $clog2(NUM_BANKS);
  localparam int RQ_AW     = $clog2(RQ_DEPTH);
  localparam int T_MAX_A   = (T_RCD > T_RP) ? T_RCD : T_RP;
  localparam int T_MAX_B   = (T_RAS > T_WR) ? T_RAS : T_WR;
  localparam int T_MAX_C   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int T_MAX     = (T_MAX_C > T_CCD) ? T_MAX_C : T_CCD;
  localparam int CW        = $clog2(T_MAX + 1);

  localparam logic [2:0] CMD_NOP   = 3'b000;
  localparam logic [2:0] CMD_ACT   = 3'b001;
  localparam logic [2:0] CMD_READ  = 3'b010;
  localparam logic [2:0] CMD_WRITE = 3'b011;
  localparam logic [2:0] CMD_PRE   = 3'b100;

  typedef logic [CW-1:0] wait_t;

  // Decrement toward zero; a load of t sets t-1 but never shortens a longer pending wait.
  function automatic wait_t next_wait(input wait_t cur, input int t, input logic load);
    wait_t dec_v;
    wait_t ld_v;
    dec_v = (cur != '0) ? (cur - wait_t'(1)) : '0;
    ld_v  = (t > 1) ? wait_t'(t - 1) : '0;
    if (load && (ld_v > dec_v)) begin
      next_wait = ld_v;
    end else begin
      next_wait = dec_v;
    end
  endfunction

  wait_t act_wait_r [NUM_BANKS];
  wait_t rw_wait_r  [NUM_BANKS];
  wait_t pre_wait_r [NUM_BANKS];
  wait_t ccd_wait_r;

  logic [PADDR_BITS-1:0] rq_mem_r [RQ_DEPTH];
  logic [RQ_AW-1:0]      rq_wr_ptr_r;
  logic [RQ_AW-1:0]      rq_rd_ptr_r;
  logic [RQ_AW:0]        rq_count_r;

  logic [2:0]            dram_cmd_r;
  logic [BG_W-1:0]       dram_bg_r;
  logic [BA_W-1:0]       dram_ba_r;
  logic [ROW_BITS-1:0]   dram_addr_r;
  logic [511:0]          dram_wdata_r;
  logic                  rsp_valid_r;
  logic [PADDR_BITS-1:0] rsp_addr_r;
  logic [511:0]          rsp_data_r;
  logic                  protocol_err_r;

  logic [BK_W-1:0]      bank_s;
  logic [NUM_BANKS-1:0] bank_hit_s;
  logic                 cmd_ready_s;
  logic                 accept_s;
  logic                 is_act_s;
  logic                 is_rd_s;
  logic                 is_wr_s;
  logic                 is_pre_s;
  logic                 is_rw_s;
  logic                 rq_full_s;
  logic                 rq_empty_s;
  logic                 rq_push_s;
  logic                 rq_pop_s;

  assign bank_s     = BK_W'(bank_group_in) * BK_W'(BANKS_PER_GROUP) + BK_W'(bank_in);
  assign bank_hit_s = {{(NUM_BANKS-1){1'b0}}, 1'b1} << bank_s;

  assign rq_full_s  = (rq_count_r == (RQ_AW+1)'(RQ_DEPTH));
  assign rq_empty_s = (rq_count_r == '0);

  // Legality of the presented command against current timing state.
  always_comb begin
    cmd_ready_s = 1'b1;
    case (cmd_in)
      CMD_ACT:   cmd_ready_s = (act_wait_r[bank_s] == '0);
      CMD_READ:  cmd_ready_s = (rw_wait_r[bank_s] == '0) && (ccd_wait_r == '0) && !rq_full_s;
      CMD_WRITE: cmd_ready_s = (rw_wait_r[bank_s] == '0) && (ccd_wait_r == '0);
      CMD_PRE:   cmd_ready_s = (pre_wait_r[bank_s] == '0);
      default:   cmd_ready_s = 1'b1;
    endcase
  end

  assign accept_s  = valid_in && cmd_ready_s;
  assign is_act_s  = accept_s && (cmd_in == CMD_ACT);
  assign is_rd_s   = accept_s && (cmd_in == CMD_READ);
  assign is_wr_s   = accept_s && (cmd_in == CMD_WRITE);
  assign is_pre_s  = accept_s && (cmd_in == CMD_PRE);
  assign is_rw_s   = is_rd_s || is_wr_s;
  assign rq_push_s = is_rd_s;
  assign rq_pop_s  = dram_rvalid_in && !rq_empty_s;

  // Per-bank and global timing counters.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        act_wait_r[i] <= '0;
        rw_wait_r[i]  <= '0;
        pre_wait_r[i] <= '0;
      end
      ccd_wait_r <= '0;
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        act_wait_r[i] <= next_wait(act_wait_r[i], T_RP, is_pre_s && bank_hit_s[i]);
        rw_wait_r[i]  <= next_wait(rw_wait_r[i], T_RCD, is_act_s && bank_hit_s[i]);
        // ACT and WRITE both gate PRE; the max-merge in next_wait combines them.
        pre_wait_r[i] <= next_wait(pre_wait_r[i], is_act_s ? T_RAS : T_WR,
                                   (is_act_s || is_wr_s) && bank_hit_s[i]);
      end
      ccd_wait_r <= next_wait(ccd_wait_r, T_CCD, is_rw_s);
    end
  end

  // Outstanding-read address storage.
  always_ff @(posedge clk_in) begin
    if (rq_push_s) begin
      rq_mem_r[rq_wr_ptr_r] <= addr_in;
    end
  end

  // Read-queue pointers and occupancy.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rq_wr_ptr_r <= '0;
      rq_rd_ptr_r <= '0;
      rq_count_r  <= '0;
    end else begin
      if (rq_push_s) begin
        rq_wr_ptr_r <= rq_wr_ptr_r + RQ_AW'(1);
      end
      if (rq_pop_s) begin
        rq_rd_ptr_r <= rq_rd_ptr_r + RQ_AW'(1);
      end
      case ({rq_push_s, rq_pop_s})
        2'b10:   rq_count_r <= rq_count_r + (RQ_AW+1)'(1);
        2'b01:   rq_count_r <= rq_count_r - (RQ_AW+1)'(1);
        default: rq_count_r <= rq_count_r;
      endcase
    end
  end

  // Registered DRAM command bus, read response and sticky protocol error.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      dram_cmd_r     <= CMD_NOP;
      dram_bg_r      <= '0;
      dram_ba_r      <= '0;
      dram_addr_r    <= '0;
      dram_wdata_r   <= '0;
      rsp_valid_r    <= 1'b0;
      rsp_addr_r     <= '0;
      rsp_data_r     <= '0;
      protocol_err_r <= 1'b0;
    end else begin
      dram_cmd_r   <= CMD_NOP;
      dram_bg_r    <= '0;
      dram_ba_r    <= '0;
      dram_addr_r  <= '0;
      dram_wdata_r <= '0;
      if (is_act_s || is_rw_s || is_pre_s) begin
        dram_cmd_r <= cmd_in;
        dram_bg_r  <= bank_group_in;
        dram_ba_r  <= bank_in;
      end
      if (is_act_s) begin
        dram_addr_r <= row_in;
      end else if (is_rw_s) begin
        dram_addr_r <= ROW_BITS'(col_in);
      end
      if (is_wr_s) begin
        dram_wdata_r <= val_in;
      end
      rsp_valid_r    <= rq_pop_s;
      rsp_addr_r     <= rq_pop_s ? rq_mem_r[rq_rd_ptr_r] : '0;
      rsp_data_r     <= rq_pop_s ? dram_rdata_in : '0;
      protocol_err_r <= protocol_err_r || (dram_rvalid_in && rq_empty_s);
    end
  end

  assign cmd_ready        = cmd_ready_s;
  assign dram_cmd_out     = dram_cmd_r;
  assign dram_bg_out      = dram_bg_r;
  assign dram_ba_out      = dram_ba_r;
  assign dram_addr_out    = dram_addr_r;
  assign dram_wdata_out   = dram_wdata_r;
  assign rsp_valid_out    = rsp_valid_r;
  assign rsp_addr_out     = rsp_addr_r;
  assign rsp_data_out     = rsp_data_r;
  assign protocol_err_out = protocol_err_r;

endmodule

// File: tb/tb_dram_cmd_issuer.sv
// Bench for dram_cmd_issuer: directed timing scenarios then random traffic,
// checked against an absolute-deadline reference model with a queue of read addresses.
module tb_dram_cmd_issuer;

  localparam int T_RCD = 8;
  localparam int T_RP  = 5;
  localparam int T_RAS = 12;
  localparam int T_WR  = 6;
  localparam int T_CCD = 2;
  localparam int RQD   = 8;
  localparam int BPG   = 8;

  localparam logic [2:0] NOP = 3'd0;
  localparam logic [2:0] ACT = 3'd1;
  localparam logic [2:0] RD  = 3'd2;
  localparam logic [2:0] WR  = 3'd3;
  localparam logic [2:0] PRE = 3'd4;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic [2:0]   cmd_in;
  logic         valid_in;
  logic [18:0]  addr_in;
  logic [2:0]   bank_group_in;
  logic [2:0]   bank_in;
  logic [7:0]   row_in;
  logic [3:0]   col_in;
  logic [511:0] val_in;
  logic         cmd_ready;
  logic [2:0]   dram_cmd_out;
  logic [2:0]   dram_bg_out;
  logic [2:0]   dram_ba_out;
  logic [7:0]   dram_addr_out;
  logic [511:0] dram_wdata_out;
  logic [511:0] dram_rdata_in;
  logic         dram_rvalid_in;
  logic         rsp_valid_out;
  logic [18:0]  rsp_addr_out;
  logic [511:0] rsp_data_out;
  logic         protocol_err_out;

  dram_cmd_issuer dut (
    .clk_in(clk_in), .rst_in(rst_in), .cmd_in(cmd_in), .valid_in(valid_in),
    .addr_in(addr_in), .bank_group_in(bank_group_in), .bank_in(bank_in),
    .row_in(row_in), .col_in(col_in), .val_in(val_in), .cmd_ready(cmd_ready),
    .dram_cmd_out(dram_cmd_out), .dram_bg_out(dram_bg_out), .dram_ba_out(dram_ba_out),
    .dram_addr_out(dram_addr_out), .dram_wdata_out(dram_wdata_out),
    .dram_rdata_in(dram_rdata_in), .dram_rvalid_in(dram_rvalid_in),
    .rsp_valid_out(rsp_valid_out), .rsp_addr_out(rsp_addr_out),
    .rsp_data_out(rsp_data_out), .protocol_err_out(protocol_err_out)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: earliest legal cycle per bank and command class.
  int          act_ok [64];
  int          rw_ok  [64];
  int          pre_ok [64];
  int          ccd_ok;
  logic [18:0] rq [$];
  logic        m_err;

  logic [2:0]   e_cmd, e_bg, e_ba;
  logic [7:0]   e_addr;
  logic [511:0] e_wdata, e_rdata;
  logic         e_rvalid;
  logic [18:0]  e_raddr;

  function automatic int maxi(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic model_ready(input logic [2:0] c, input int b);
    case (c)
      ACT:     return cyc >= act_ok[b];
      RD:      return (cyc >= rw_ok[b]) && (cyc >= ccd_ok) && (rq.size() < RQD);
      WR:      return (cyc >= rw_ok[b]) && (cyc >= ccd_ok);
      PRE:     return cyc >= pre_ok[b];
      default: return 1'b1;
    endcase
  endfunction

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    valid_in = 1'b0; dram_rvalid_in = 1'b0; cmd_in = NOP;
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    cyc++;
    for (int b = 0; b < 64; b++) begin act_ok[b] = 0; rw_ok[b] = 0; pre_ok[b] = 0; end
    ccd_ok = 0; rq.delete(); m_err = 1'b0;
    check("rst_dram_cmd", 512'(dram_cmd_out), 512'(3'd0));
    check("rst_wdata", dram_wdata_out, 512'h0);
    check("rst_rsp_valid", 512'(rsp_valid_out), 512'(1'b0));
    check("rst_err", 512'(protocol_err_out), 512'(1'b0));
  endtask

  // One cycle: drive, check readiness, advance model, clock, check registered outputs.
  task automatic tick(input logic [2:0] c, input logic v, input logic [2:0] bg, input logic [2:0] ba,
                      input logic [7:0] row, input logic [3:0] col, input logic [18:0] a,
                      input logic [511:0] wd, input logic rv, input logic [511:0] rd,
                      output logic rdy);
    int   b;
    logic er;
    logic acc;
    cmd_in = c; valid_in = v; bank_group_in = bg; bank_in = ba; row_in = row;
    col_in = col; addr_in = a; val_in = wd; dram_rvalid_in = rv; dram_rdata_in = rd;
    #1;
    b  = int'(bg) * BPG + int'(ba);
    er = model_ready(c, b);
    check("cmd_ready", 512'(cmd_ready), 512'(er));
    rdy = cmd_ready;
    acc = v && er;
    e_cmd = 3'd0; e_bg = 3'd0; e_ba = 3'd0; e_addr = 8'd0; e_wdata = 512'h0;
    if (acc && (c >= ACT) && (c <= PRE)) begin
      e_cmd = c; e_bg = bg; e_ba = ba;
      if (c == ACT) e_addr = row;
      else if ((c == RD) || (c == WR)) e_addr = {4'd0, col};
      if (c == WR) e_wdata = wd;
    end
    e_rvalid = 1'b0; e_raddr = 19'd0; e_rdata = 512'h0;
    if (rv) begin
      if (rq.size() == 0) m_err = 1'b1;
      else begin e_rvalid = 1'b1; e_raddr = rq.pop_front(); e_rdata = rd; end
    end
    if (acc) begin
      case (c)
        ACT: begin rw_ok[b] = maxi(rw_ok[b], cyc + T_RCD); pre_ok[b] = maxi(pre_ok[b], cyc + T_RAS); end
        RD:  begin ccd_ok = maxi(ccd_ok, cyc + T_CCD); rq.push_back(a); end
        WR:  begin ccd_ok = maxi(ccd_ok, cyc + T_CCD); pre_ok[b] = maxi(pre_ok[b], cyc + T_WR); end
        PRE: act_ok[b] = maxi(act_ok[b], cyc + T_RP);
        default: ;
      endcase
    end
    @(posedge clk_in); #1;
    cyc++;
    check("dram_cmd", 512'(dram_cmd_out), 512'(e_cmd));
    check("dram_bg", 512'(dram_bg_out), 512'(e_bg));
    check("dram_ba", 512'(dram_ba_out), 512'(e_ba));
    check("dram_addr", 512'(dram_addr_out), 512'(e_addr));
    check("dram_wdata", dram_wdata_out, e_wdata);
    check("rsp_valid", 512'(rsp_valid_out), 512'(e_rvalid));
    check("rsp_addr", 512'(rsp_addr_out), 512'(e_raddr));
    check("rsp_data", rsp_data_out, e_rdata);
    check("protocol_err", 512'(protocol_err_out), 512'(m_err));
  endtask

  task automatic issue(input logic [2:0] c, input logic [2:0] bg, input logic [2:0] ba,
                       input logic [18:0] a);
    logic rdy;
    int   n;
    rdy = 1'b0; n = 0;
    while (!rdy && (n < 16)) begin
      tick(c, 1'b1, bg, ba, 8'h00, 4'h1, a, 512'h0, 1'b0, 512'h0, rdy);
      n++;
    end
    check("issue_done", 512'(rdy), 512'(1'b1));
  endtask

  task automatic nop(input logic rv, input logic [511:0] rd);
    logic rdy;
    tick(NOP, 1'b0, 3'd0, 3'd0, 8'h00, 4'h0, 19'h0, 512'h0, rv, rd, rdy);
  endtask

  initial begin
    logic         rdy;
    logic [511:0] d0;
    logic [511:0] wpat;
    logic [2:0]   c;
    logic         rv;
    d0   = rand512();
    wpat = 512'hA5A5A5A5A5A5A5A5;
    cmd_in = NOP; valid_in = 1'b0; addr_in = 19'h0; bank_group_in = 3'd0; bank_in = 3'd0;
    row_in = 8'h0; col_in = 4'h0; val_in = 512'h0; dram_rdata_in = 512'h0; dram_rvalid_in = 1'b0;
    do_reset();

    // ACT -> READ same bank waits T_RCD
    tick(ACT, 1'b1, 3'd3, 3'd2, 8'h55, 4'h0, 19'h0, 512'h0, 1'b0, 512'h0, rdy);
    check("t1_act_ready", 512'(rdy), 512'(1'b1));
    check("t1_act_row", 512'(dram_addr_out), 512'(8'h55));
    for (int k = 1; k <= 7; k++) begin
      tick(RD, 1'b1, 3'd3, 3'd2, 8'h00, 4'hA, 19'h0AA, 512'h0, 1'b0, 512'h0, rdy);
      check("t1_rd_blocked", 512'(rdy), 512'(1'b0));
    end
    tick(RD, 1'b1, 3'd3, 3'd2, 8'h00, 4'hA, 19'h0AA, 512'h0, 1'b0, 512'h0, rdy);
    check("t1_rd_accept", 512'(rdy), 512'(1'b1));
    check("t1_rd_cmd", 512'(dram_cmd_out), 512'(3'b010));
    check("t1_rd_addr", 512'(dram_addr_out), 512'(8'h0A));

    // ACT, WRITE at +8, PRE held to max(tRAS, WRITE+tWR) = +14
    tick(ACT, 1'b1, 3'd2, 3'd1, 8'h12, 4'h0, 19'h0, 512'h0, 1'b0, 512'h0, rdy);
    check("t2_act_ready", 512'(rdy), 512'(1'b1));
    for (int k = 1; k <= 7; k++) begin
      tick(WR, 1'b1, 3'd2, 3'd1, 8'h00, 4'h3, 19'h0, wpat, 1'b0, 512'h0, rdy);
      check("t2_wr_blocked", 512'(rdy), 512'(1'b0));
    end
    tick(WR, 1'b1, 3'd2, 3'd1, 8'h00, 4'h3, 19'h0, wpat, 1'b0, 512'h0, rdy);
    check("t2_wr_accept", 512'(rdy), 512'(1'b1));
    check("t2_wr_cmd", 512'(dram_cmd_out), 512'(3'b011));
    check("t2_wr_data", dram_wdata_out, wpat);
    for (int k = 9; k <= 13; k++) begin
      tick(PRE, 1'b1, 3'd2, 3'd1, 8'h00, 4'h0, 19'h0, 512'h0, 1'b0, 512'h0, rdy);
      check("t2_pre_blocked", 512'(rdy), 512'(1'b0));
    end
    tick(PRE, 1'b1, 3'd2, 3'd1, 8'h00, 4'h0, 19'h0, 512'h0, 1'b0, 512'h0, rdy);
    check("t2_pre_accept", 512'(rdy), 512'(1'b1));

    // PRE -> ACT same bank waits T_RP; neighbour bank unaffected
    tick(PRE, 1'b1, 3'd1, 3'd1, 8'h00, 4'h0, 19'h0, 512'h0, 1'b0, 512'h0, rdy);
    check("t3_pre_ready", 512'(rdy), 512'(1'b1));
    tick(ACT, 1'b1, 3'd1, 3'd2, 8'h33, 4'h0, 19'h0, 512'h0, 1'b0, 512'h0, rdy);
    check("t3_other_bank", 512'(rdy), 512'(1'b1));
    for (int k = 2; k <= 4; k++) begin
      tick(ACT, 1'b1, 3'd1, 3'd1, 8'h44, 4'h0, 19'h0, 512'h0, 1'b0, 512'h0, rdy);
      check("t3_act_blocked", 512'(rdy), 512'(1'b0));
    end
    tick(ACT, 1'b1, 3'd1, 3'd1, 8'h44, 4'h0, 19'h0, 512'h0, 1'b0, 512'h0, rdy);
    check("t3_act_accept", 512'(rdy), 512'(1'b1));

    // Back-to-back READs to different banks are spaced by T_CCD
    issue(ACT, 3'd4, 3'd0, 19'h0);
    issue(ACT, 3'd4, 3'd1, 19'h0);
    for (int k = 0; k < 8; k++) nop(1'b0, 512'h0);
    tick(RD, 1'b1, 3'd4, 3'd0, 8'h00, 4'h1, 19'h200, 512'h0, 1'b0, 512'h0, rdy);
    check("t4_rd0_accept", 512'(rdy), 512'(1'b1));
    tick(RD, 1'b1, 3'd4, 3'd1, 8'h00, 4'h2, 19'h201, 512'h0, 1'b0, 512'h0, rdy);
    check("t4_rd1_ccd", 512'(rdy), 512'(1'b0));
    tick(RD, 1'b1, 3'd4, 3'd1, 8'h00, 4'h2, 19'h201, 512'h0, 1'b0, 512'h0, rdy);
    check("t4_rd1_accept", 512'(rdy), 512'(1'b1));
    nop(1'b1, rand512());
    check("t4_rsp_first", 512'(rsp_addr_out), 512'(19'h0AA));
    nop(1'b1, rand512());
    nop(1'b1, rand512());

    // Read queue fills at RQ_DEPTH; full is judged before a same-cycle pop
    for (int i = 0; i < 8; i++) issue(RD, 3'd4, 3'd0, 19'h100 + 19'(i));
    for (int k = 0; k < 2; k++) begin
      tick(RD, 1'b1, 3'd4, 3'd0, 8'h00, 4'h1, 19'h108, 512'h0, 1'b0, 512'h0, rdy);
      check("t5_full_blocked", 512'(rdy), 512'(1'b0));
    end
    tick(RD, 1'b1, 3'd4, 3'd0, 8'h00, 4'h1, 19'h108, 512'h0, 1'b1, d0, rdy);
    check("t5_full_with_pop", 512'(rdy), 512'(1'b0));
    check("t5_rsp_valid", 512'(rsp_valid_out), 512'(1'b1));
    check("t5_rsp_addr", 512'(rsp_addr_out), 512'(19'h100));
    check("t5_rsp_data", rsp_data_out, d0);
    tick(RD, 1'b1, 3'd4, 3'd0, 8'h00, 4'h1, 19'h108, 512'h0, 1'b0, 512'h0, rdy);
    check("t5_ninth_accept", 512'(rdy), 512'(1'b1));

    // Empty-queue rvalid is sticky until reset; reset discards pending timing
    for (int k = 0; k < 8; k++) nop(1'b1, rand512());
    nop(1'b1, rand512());
    check("t6_err_set", 512'(protocol_err_out), 512'(1'b1));
    for (int k = 0; k < 3; k++) nop(1'b0, 512'h0);
    check("t6_err_sticky", 512'(protocol_err_out), 512'(1'b1));
    issue(PRE, 3'd5, 3'd5, 19'h0);
    do_reset();
    tick(ACT, 1'b1, 3'd5, 3'd5, 8'h77, 4'h0, 19'h0, 512'h0, 1'b0, 512'h0, rdy);
    check("t6_act_after_rst", 512'(rdy), 512'(1'b1));
    nop(1'b1, rand512());
    check("t6_queue_empty", 512'(rsp_valid_out), 512'(1'b0));
    check("t6_err_again", 512'(protocol_err_out), 512'(1'b1));

    // Random traffic on a few banks to provoke timing conflicts and queue pressure
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 9))
        0:         c = NOP;
        1, 2:      c = ACT;
        3, 4, 5:   c = RD;
        6, 7:      c = WR;
        default:   c = PRE;
      endcase
      if ($urandom_range(0, 19) == 0) c = 3'($urandom_range(5, 7));
      if (rq.size() > 0) rv = ($urandom_range(0, 3) == 0);
      else rv = ($urandom_range(0, 49) == 0);
      tick(c, ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 1)), 3'($urandom_range(0, 1)),
           8'($urandom), 4'($urandom), 19'($urandom), rand512(), rv, rand512(), rdy);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
